// File: rtl/axi4_id_remapper.sv
// ---------------------------------------------------------------------------
// axi4_id_remapper
//   Compacts a wide upstream AXI4 ID space onto a narrow downstream one via
//   tracked allocation tables (one for reads, one for writes). Each slot
//   records the owning upstream ID and the number of outstanding bursts, so
//   responses get their original ID back from the table and per-ID ordering
//   is kept (one ID never occupies two slots at once).
//   All outputs are combinational from inputs and table state.
//
// Ports
//   clock, reset (async, active-low)
//   in_ar_* / out_ar_*  read address, upstream -> downstream, ID remapped
//   in_aw_* / out_aw_*  write address, upstream -> downstream, ID remapped
//   in_w_*  / out_w_*   write data, pure wire-through
//   out_r_* / in_r_*    read data, downstream -> upstream, ID restored
//   out_b_* / in_b_*    write response, downstream -> upstream, ID restored
//   err_sticky          protocol error flag (only with AXI4_ID_REMAP_CHECK_EN)
//
// Configuration
//   AXI4_ID_REMAP_CHECK_EN : when defined, adds err_sticky, set by a response
//   to a slot with no outstanding bursts; cleared only by reset.
// ---------------------------------------------------------------------------

// One allocation table: slot choice for new requests, bookkeeping of
// outstanding bursts, and ID lookup for responses.
module axi4_id_remap_table #(
  parameter int IN_ID_W  = 6,
  parameter int OUT_ID_W = 2,
  parameter int MAX_OUT  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [IN_ID_W-1:0]  req_id,
  input  logic                req_fire,
  output logic                acc_ok,
  output logic [OUT_ID_W-1:0] acc_slot,
  input  logic                rsp_retire,
  input  logic [OUT_ID_W-1:0] rsp_slot,
  output logic [IN_ID_W-1:0]  rsp_id
`ifdef AXI4_ID_REMAP_CHECK_EN
  ,
  input  logic                rsp_fire,
  output logic                rsp_err
`endif
);
  localparam int N  = 2**OUT_ID_W;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [N-1:0]               vld_q, vld_d;
  logic [N-1:0][IN_ID_W-1:0]  id_q, id_d;
  logic [N-1:0][CW-1:0]       cnt_q, cnt_d;
  logic                       lock_q, lock_d;
  logic [OUT_ID_W-1:0]        lock_slot_q, lock_slot_d;

  logic                       hit_s, free_s, inc_s, dec_s;
  logic [OUT_ID_W-1:0]        hit_slot_s, free_slot_s;

  // Find the slot owned by req_id and the lowest-index free slot.
  always_comb begin
    hit_s       = 1'b0;
    hit_slot_s  = {OUT_ID_W{1'b0}};
    free_s      = 1'b0;
    free_slot_s = {OUT_ID_W{1'b0}};
    // Descending scan: the last free slot written is the lowest index.
    for (int i = N-1; i >= 0; i--) begin
      if (vld_q[i] && (id_q[i] == req_id)) begin
        hit_s      = 1'b1;
        hit_slot_s = OUT_ID_W'(i);
      end else if (!vld_q[i]) begin
        free_s      = 1'b1;
        free_slot_s = OUT_ID_W'(i);
      end else begin
      end
    end
  end

  // Accept decision. A request already presented downstream keeps its slot
  // until it fires, so a retire elsewhere cannot change out_*_id mid-handshake;
  // the locked slot stays usable because only this channel allocates.
  always_comb begin
    acc_ok   = 1'b0;
    acc_slot = {OUT_ID_W{1'b0}};
    if (lock_q) begin
      acc_ok   = 1'b1;
      acc_slot = lock_slot_q;
    end else if (hit_s) begin
      acc_ok   = (cnt_q[hit_slot_s] != CNT_MAX);
      acc_slot = hit_slot_s;
    end else begin
      acc_ok   = free_s;
      acc_slot = free_slot_s;
    end
    lock_d      = req_valid & acc_ok & ~req_fire;
    lock_slot_d = acc_slot;
  end

  // Response side: ID restore and optional error detection.
  assign rsp_id = id_q[rsp_slot];
`ifdef AXI4_ID_REMAP_CHECK_EN
  assign rsp_err = rsp_fire & (cnt_q[rsp_slot] == CNT_ZERO);
`endif

  // Table next state: accept increments, last-beat retire decrements
  // (saturating at zero); both on one slot leave it unchanged and valid.
  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    cnt_d = cnt_q;
    inc_s = 1'b0;
    dec_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      inc_s = req_fire & (acc_slot == OUT_ID_W'(i));
      dec_s = rsp_retire & (rsp_slot == OUT_ID_W'(i)) & (cnt_q[i] != CNT_ZERO);
      if (inc_s && !dec_s) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
        vld_d[i] = 1'b1;
        id_d[i]  = req_id;
      end else if (!inc_s && dec_s) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
        vld_d[i] = (cnt_q[i] != CNT_ONE);
      end else if (inc_s && dec_s) begin
        vld_d[i] = 1'b1;
        id_d[i]  = req_id;
      end else begin
      end
    end
  end

  // Table and slot-lock registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q       <= {N{1'b0}};
      id_q        <= '0;
      cnt_q       <= '0;
      lock_q      <= 1'b0;
      lock_slot_q <= {OUT_ID_W{1'b0}};
    end else begin
      vld_q       <= vld_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      lock_q      <= lock_d;
      lock_slot_q <= lock_slot_d;
    end
  end
endmodule

module axi4_id_remapper #(
  parameter int IN_ID_W  = 6,
  parameter int OUT_ID_W = 2,
  parameter int MAX_OUT  = 4,
  parameter int AR_PW    = 64,
  parameter int AW_PW    = 64,
  parameter int R_PW     = 67,
  parameter int B_PW     = 2,
  parameter int W_DW     = 64,
  parameter int W_SW     = W_DW / 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_ar_valid,
  output logic                in_ar_ready,
  input  logic [IN_ID_W-1:0]  in_ar_id,
  input  logic [AR_PW-1:0]    in_ar_payload,
  output logic                out_ar_valid,
  input  logic                out_ar_ready,
  output logic [OUT_ID_W-1:0] out_ar_id,
  output logic [AR_PW-1:0]    out_ar_payload,
  input  logic                in_aw_valid,
  output logic                in_aw_ready,
  input  logic [IN_ID_W-1:0]  in_aw_id,
  input  logic [AW_PW-1:0]    in_aw_payload,
  output logic                out_aw_valid,
  input  logic                out_aw_ready,
  output logic [OUT_ID_W-1:0] out_aw_id,
  output logic [AW_PW-1:0]    out_aw_payload,
  input  logic                in_w_valid,
  output logic                in_w_ready,
  input  logic [W_DW-1:0]     in_w_data,
  input  logic [W_SW-1:0]     in_w_strb,
  input  logic                in_w_last,
  output logic                out_w_valid,
  input  logic                out_w_ready,
  output logic [W_DW-1:0]     out_w_data,
  output logic [W_SW-1:0]     out_w_strb,
  output logic                out_w_last,
  input  logic                out_r_valid,
  output logic                out_r_ready,
  input  logic [OUT_ID_W-1:0] out_r_id,
  input  logic                out_r_last,
  input  logic [R_PW-1:0]     out_r_payload,
  output logic                in_r_valid,
  input  logic                in_r_ready,
  output logic [IN_ID_W-1:0]  in_r_id,
  output logic                in_r_last,
  output logic [R_PW-1:0]     in_r_payload,
  input  logic                out_b_valid,
  output logic                out_b_ready,
  input  logic [OUT_ID_W-1:0] out_b_id,
  input  logic [B_PW-1:0]     out_b_payload,
  output logic                in_b_valid,
  input  logic                in_b_ready,
  output logic [IN_ID_W-1:0]  in_b_id,
  output logic [B_PW-1:0]     in_b_payload
`ifdef AXI4_ID_REMAP_CHECK_EN
  ,
  output logic                err_sticky
`endif
);
  logic ar_acc_ok_s, ar_fire_s, aw_acc_ok_s, aw_fire_s;
  logic r_fire_s, r_retire_s, b_fire_s;

  // Address channels: valid/ready gated by the accept decision only.
  assign out_ar_valid   = in_ar_valid & ar_acc_ok_s;
  assign in_ar_ready    = out_ar_ready & ar_acc_ok_s;
  assign ar_fire_s      = in_ar_valid & out_ar_ready & ar_acc_ok_s;
  assign out_ar_payload = in_ar_payload;
  assign out_aw_valid   = in_aw_valid & aw_acc_ok_s;
  assign in_aw_ready    = out_aw_ready & aw_acc_ok_s;
  assign aw_fire_s      = in_aw_valid & out_aw_ready & aw_acc_ok_s;
  assign out_aw_payload = in_aw_payload;

  // Write data is untouched.
  assign out_w_valid = in_w_valid;
  assign in_w_ready  = out_w_ready;
  assign out_w_data  = in_w_data;
  assign out_w_strb  = in_w_strb;
  assign out_w_last  = in_w_last;

  // Response channels: handshake and payload pass straight through.
  assign in_r_valid   = out_r_valid;
  assign out_r_ready  = in_r_ready;
  assign in_r_last    = out_r_last;
  assign in_r_payload = out_r_payload;
  assign r_fire_s     = out_r_valid & in_r_ready;
  assign r_retire_s   = r_fire_s & out_r_last;
  assign in_b_valid   = out_b_valid;
  assign out_b_ready  = in_b_ready;
  assign in_b_payload = out_b_payload;
  assign b_fire_s     = out_b_valid & in_b_ready;

`ifdef AXI4_ID_REMAP_CHECK_EN
  logic rd_err_s, wr_err_s, err_q, err_d;
`endif

  axi4_id_remap_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)) u_rd_tab (
    .clock(clock), .reset(reset),
    .req_valid(in_ar_valid), .req_id(in_ar_id), .req_fire(ar_fire_s),
    .acc_ok(ar_acc_ok_s), .acc_slot(out_ar_id),
    .rsp_retire(r_retire_s), .rsp_slot(out_r_id), .rsp_id(in_r_id)
`ifdef AXI4_ID_REMAP_CHECK_EN
    , .rsp_fire(r_fire_s), .rsp_err(rd_err_s)
`endif
  );

  axi4_id_remap_table #(.IN_ID_W(IN_ID_W), .OUT_ID_W(OUT_ID_W), .MAX_OUT(MAX_OUT)) u_wr_tab (
    .clock(clock), .reset(reset),
    .req_valid(in_aw_valid), .req_id(in_aw_id), .req_fire(aw_fire_s),
    .acc_ok(aw_acc_ok_s), .acc_slot(out_aw_id),
    .rsp_retire(b_fire_s), .rsp_slot(out_b_id), .rsp_id(in_b_id)
`ifdef AXI4_ID_REMAP_CHECK_EN
    , .rsp_fire(b_fire_s), .rsp_err(wr_err_s)
`endif
  );

`ifdef AXI4_ID_REMAP_CHECK_EN
  // Sticky error accumulation.
  always_comb begin
    err_d = err_q | rd_err_s | wr_err_s;
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sticky = err_q;
`endif
endmodule

// File: tb/tb_axi4_id_remapper.sv
module tb_axi4_id_remapper;
  logic        clock, reset;
  logic        in_ar_valid, in_ar_ready, out_ar_valid, out_ar_ready;
  logic [5:0]  in_ar_id;
  logic [63:0] in_ar_payload, out_ar_payload;
  logic [1:0]  out_ar_id;
  logic        in_aw_valid, in_aw_ready, out_aw_valid, out_aw_ready;
  logic [5:0]  in_aw_id;
  logic [63:0] in_aw_payload, out_aw_payload;
  logic [1:0]  out_aw_id;
  logic        in_w_valid, in_w_ready, in_w_last, out_w_valid, out_w_ready, out_w_last;
  logic [63:0] in_w_data, out_w_data;
  logic [7:0]  in_w_strb, out_w_strb;
  logic        out_r_valid, out_r_ready, out_r_last, in_r_valid, in_r_ready, in_r_last;
  logic [1:0]  out_r_id;
  logic [66:0] out_r_payload, in_r_payload;
  logic [5:0]  in_r_id;
  logic        out_b_valid, out_b_ready, in_b_valid, in_b_ready;
  logic [1:0]  out_b_id, out_b_payload, in_b_payload;
  logic [5:0]  in_b_id;
`ifdef AXI4_ID_REMAP_CHECK_EN
  logic        err_sticky;
`endif

  axi4_id_remapper dut (
    .clock(clock), .reset(reset),
    .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready), .in_ar_id(in_ar_id),
    .in_ar_payload(in_ar_payload), .out_ar_valid(out_ar_valid), .out_ar_ready(out_ar_ready),
    .out_ar_id(out_ar_id), .out_ar_payload(out_ar_payload),
    .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready), .in_aw_id(in_aw_id),
    .in_aw_payload(in_aw_payload), .out_aw_valid(out_aw_valid), .out_aw_ready(out_aw_ready),
    .out_aw_id(out_aw_id), .out_aw_payload(out_aw_payload),
    .in_w_valid(in_w_valid), .in_w_ready(in_w_ready), .in_w_data(in_w_data),
    .in_w_strb(in_w_strb), .in_w_last(in_w_last), .out_w_valid(out_w_valid),
    .out_w_ready(out_w_ready), .out_w_data(out_w_data), .out_w_strb(out_w_strb),
    .out_w_last(out_w_last),
    .out_r_valid(out_r_valid), .out_r_ready(out_r_ready), .out_r_id(out_r_id),
    .out_r_last(out_r_last), .out_r_payload(out_r_payload), .in_r_valid(in_r_valid),
    .in_r_ready(in_r_ready), .in_r_id(in_r_id), .in_r_last(in_r_last),
    .in_r_payload(in_r_payload),
    .out_b_valid(out_b_valid), .out_b_ready(out_b_ready), .out_b_id(out_b_id),
    .out_b_payload(out_b_payload), .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
    .in_b_id(in_b_id), .in_b_payload(in_b_payload)
`ifdef AXI4_ID_REMAP_CHECK_EN
    , .err_sticky(err_sticky)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_ar[$], exp_aw[$], exp_w[$], exp_r[$], exp_b[$];
  logic [127:0] mon_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected_transfer required=none", name);
  endtask

  // Scoreboard monitor: compare every DUT-side transfer against the queues.
  always @(negedge clock) begin
    if (reset) begin
      if (out_ar_valid && out_ar_ready) begin
        if (exp_ar.size() == 0) unexpected("ar");
        else begin mon_e = exp_ar.pop_front(); check("ar", 128'({out_ar_id, out_ar_payload}), mon_e); end
      end
      if (out_aw_valid && out_aw_ready) begin
        if (exp_aw.size() == 0) unexpected("aw");
        else begin mon_e = exp_aw.pop_front(); check("aw", 128'({out_aw_id, out_aw_payload}), mon_e); end
      end
      if (out_w_valid && out_w_ready) begin
        if (exp_w.size() == 0) unexpected("w");
        else begin mon_e = exp_w.pop_front(); check("w", 128'({out_w_data, out_w_strb, out_w_last}), mon_e); end
      end
      if (in_r_valid && in_r_ready) begin
        if (exp_r.size() == 0) unexpected("r");
        else begin mon_e = exp_r.pop_front(); check("r", 128'({in_r_id, in_r_last, in_r_payload}), mon_e); end
      end
      if (in_b_valid && in_b_ready) begin
        if (exp_b.size() == 0) unexpected("b");
        else begin mon_e = exp_b.pop_front(); check("b", 128'({in_b_id, in_b_payload}), mon_e); end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic ar_start(input logic [5:0] id, input logic [63:0] pl, input logic [1:0] slot);
    in_ar_valid = 1'b1; in_ar_id = id; in_ar_payload = pl;
    exp_ar.push_back(128'({slot, pl}));
  endtask

  task automatic ar_wait(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      ok = (in_ar_ready === 1'b1);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL %s actual=no_accept required=accept", name);
    end
    cyc();
    in_ar_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [5:0] id, input logic [63:0] pl, input logic [1:0] slot);
    ar_start(id, pl, slot);
    ar_wait("ar_accept");
  endtask

  task automatic aw_send(input logic [5:0] id, input logic [63:0] pl, input logic [1:0] slot);
    bit ok = 1'b0;
    in_aw_valid = 1'b1; in_aw_id = id; in_aw_payload = pl;
    exp_aw.push_back(128'({slot, pl}));
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clock);
      ok = (in_aw_ready === 1'b1);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL aw_accept actual=no_accept required=accept");
    end
    cyc();
    in_aw_valid = 1'b0;
  endtask

  task automatic r_send(input logic [1:0] slot, input logic last, input logic [66:0] pl,
                        input logic [5:0] exp_id);
    out_r_valid = 1'b1; out_r_id = slot; out_r_last = last; out_r_payload = pl;
    exp_r.push_back(128'({exp_id, last, pl}));
    @(negedge clock);
    check("r_ready", 128'(out_r_ready), 128'(1'b1));
    cyc();
    out_r_valid = 1'b0;
  endtask

  task automatic b_send(input logic [1:0] slot, input logic [1:0] pl, input logic [5:0] exp_id);
    out_b_valid = 1'b1; out_b_id = slot; out_b_payload = pl;
    exp_b.push_back(128'({exp_id, pl}));
    @(negedge clock);
    check("b_ready", 128'(out_b_ready), 128'(1'b1));
    cyc();
    out_b_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic last);
    in_w_valid = 1'b1; in_w_data = d; in_w_strb = s; in_w_last = last;
    exp_w.push_back(128'({d, s, last}));
    @(negedge clock);
    check("w_ready", 128'(in_w_ready), 128'(1'b1));
    cyc();
    in_w_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    in_ar_valid = 1'b0; in_ar_id = 6'd0; in_ar_payload = 64'd0; out_ar_ready = 1'b1;
    in_aw_valid = 1'b0; in_aw_id = 6'd0; in_aw_payload = 64'd0; out_aw_ready = 1'b1;
    in_w_valid = 1'b0; in_w_data = 64'd0; in_w_strb = 8'd0; in_w_last = 1'b0; out_w_ready = 1'b1;
    out_r_valid = 1'b0; out_r_id = 2'd0; out_r_last = 1'b0; out_r_payload = 67'd0; in_r_ready = 1'b1;
    out_b_valid = 1'b0; out_b_id = 2'd0; out_b_payload = 2'd0; in_b_ready = 1'b1;
    repeat (3) cyc();
    reset = 1'b1;
    @(negedge clock);
    check("rst_ar_valid", 128'(out_ar_valid), 128'(1'b0));
    check("rst_r_valid", 128'(in_r_valid), 128'(1'b0));
    check("rst_ar_ready", 128'(in_ar_ready), 128'(1'b1));
`ifdef AXI4_ID_REMAP_CHECK_EN
    check("rst_err", 128'(err_sticky), 128'(1'b0));
`endif

    // 1: first AR gets slot 0; valid held while downstream not ready.
    cyc();
    out_ar_ready = 1'b0;
    ar_start(6'h2A, 64'hA000_0000_0000_0001, 2'd0);
    @(negedge clock);
    check("t1_hold_valid", 128'(out_ar_valid), 128'(1'b1));
    check("t1_hold_id", 128'(out_ar_id), 128'(2'd0));
    check("t1_hold_ready", 128'(in_ar_ready), 128'(1'b0));
    cyc();
    out_ar_ready = 1'b1;
    ar_wait("t1_accept");
    r_send(2'd0, 1'b1, 67'h5_0000_0000_0000_0001, 6'h2A);

    // 2: MAX_OUT bursts on one ID, the fifth stalls until a last beat.
    for (int k = 0; k < 4; k++) ar_send(6'h05, 64'hB000_0000_0000_0000 + 64'(k), 2'd0);
    ar_start(6'h05, 64'hB000_0000_0000_0005, 2'd0);
    @(negedge clock);
    check("t2_stall_ready", 128'(in_ar_ready), 128'(1'b0));
    check("t2_stall_valid", 128'(out_ar_valid), 128'(1'b0));
    cyc();
    r_send(2'd0, 1'b0, 67'h1_2345_6789_ABCD_EF01, 6'h05);
    @(negedge clock);
    check("t2_stall_nonlast", 128'(in_ar_ready), 128'(1'b0));
    cyc();
    r_send(2'd0, 1'b1, 67'h2_0000_0000_0000_0002, 6'h05);
    ar_wait("t2_fifth");
    for (int k = 0; k < 4; k++) r_send(2'd0, 1'b1, 67'h3_0000_0000_0000_0000 + 67'(k), 6'h05);

    // 3: four IDs fill all slots; freed slot 2 is reused by the stalled ID.
    for (int k = 0; k < 4; k++) ar_send(6'h10 + 6'(k), 64'hC000_0000_0000_0000 + 64'(k), 2'(k));
    ar_start(6'h14, 64'hC000_0000_0000_0014, 2'd2);
    @(negedge clock);
    check("t3_stall_ready", 128'(in_ar_ready), 128'(1'b0));
    cyc();
    r_send(2'd2, 1'b1, 67'h4_0000_0000_0000_0012, 6'h12);
    @(negedge clock);
    check("t3_ready_next", 128'(in_ar_ready), 128'(1'b1));
    check("t3_slot_next", 128'(out_ar_id), 128'(2'd2));
    cyc();
    in_ar_valid = 1'b0;
    r_send(2'd2, 1'b1, 67'h4_0000_0000_0000_0014, 6'h14);

    // 4: same-cycle accept and retire on slot 1 with one outstanding burst.
    in_ar_valid = 1'b1; in_ar_id = 6'h11; in_ar_payload = 64'hD000_0000_0000_0011;
    exp_ar.push_back(128'({2'd1, 64'hD000_0000_0000_0011}));
    out_r_valid = 1'b1; out_r_id = 2'd1; out_r_last = 1'b1; out_r_payload = 67'h6_0000_0000_0000_0011;
    exp_r.push_back(128'({6'h11, 1'b1, 67'h6_0000_0000_0000_0011}));
    @(negedge clock);
    check("t4_ready", 128'(in_ar_ready), 128'(1'b1));
    cyc();
    in_ar_valid = 1'b0; out_r_valid = 1'b0;
    ar_send(6'h16, 64'hD000_0000_0000_0016, 2'd2);
    ar_send(6'h11, 64'hD000_0000_0000_0111, 2'd1);
    r_send(2'd1, 1'b1, 67'h6_0000_0000_0000_0001, 6'h11);
    r_send(2'd1, 1'b1, 67'h6_0000_0000_0000_0002, 6'h11);
    r_send(2'd2, 1'b1, 67'h6_0000_0000_0000_0003, 6'h16);
    r_send(2'd0, 1'b1, 67'h6_0000_0000_0000_0004, 6'h10);
    r_send(2'd3, 1'b1, 67'h6_0000_0000_0000_0005, 6'h13);
    ar_send(6'h15, 64'hD000_0000_0000_0015, 2'd0);
    r_send(2'd0, 1'b1, 67'h6_0000_0000_0000_0006, 6'h15);

    // 5: write path remap, W wire-through, B restores ID and frees the slot.
    aw_send(6'h3F, 64'hE000_0000_0000_003F, 2'd0);
    w_send(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    w_send(64'hFEDC_BA98_7654_3210, 8'h0F, 1'b1);
    b_send(2'd0, 2'b10, 6'h3F);
    aw_send(6'h01, 64'hE000_0000_0000_0001, 2'd0);
    aw_send(6'h02, 64'hE000_0000_0000_0002, 2'd1);
`ifdef AXI4_ID_REMAP_CHECK_EN
    @(negedge clock);
    check("t6_err_clean", 128'(err_sticky), 128'(1'b0));
    cyc();
`endif

    // 6: B to never-allocated slot 3 is forwarded; error flag when enabled.
    b_send(2'd3, 2'b11, 6'h00);
`ifdef AXI4_ID_REMAP_CHECK_EN
    @(negedge clock);
    check("t6_err_set", 128'(err_sticky), 128'(1'b1));
    repeat (3) cyc();
    @(negedge clock);
    check("t6_err_hold", 128'(err_sticky), 128'(1'b1));
`endif
    cyc();
    reset = 1'b0;
    @(negedge clock);
`ifdef AXI4_ID_REMAP_CHECK_EN
    check("t6_err_reset", 128'(err_sticky), 128'(1'b0));
`endif
    check("rst_mid_b_valid", 128'(in_b_valid), 128'(1'b0));
    cyc();
    reset = 1'b1;
    // Table cleared: slot 0 (previously ID 0x01) is free again.
    aw_send(6'h09, 64'hE000_0000_0000_0009, 2'd0);
    b_send(2'd0, 2'b01, 6'h09);

    repeat (3) cyc();
    check("ar_leftover", 128'(exp_ar.size()), 128'd0);
    check("aw_leftover", 128'(exp_aw.size()), 128'd0);
    check("w_leftover", 128'(exp_w.size()), 128'd0);
    check("r_leftover", 128'(exp_r.size()), 128'd0);
    check("b_leftover", 128'(exp_b.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
